mux2to1: RTL and testbench

//   Word-wide 2:1 data selector for the datapath (operand, writeback and PC-source selection).
//   - select=0 passes in1; select=1 passes in2.
//   - The primary output is combinational, so the value is valid in the same timestep as the inputs.
//   - The clock and reset drive only the optional registered copy and the select-event flag.

---
 rtl/mux2to1.sv | 64 ++++++
 tb/tb_mux2to1.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux2to1.sv
// rtl/mux2to1.sv - word-wide 2:1 selector with select-change flag and optional registered copy
// Macro MUX2TO1_OUT_REG_EN: defined -> out_q is a register, undefined -> out_q follows out.
module mux2to1 #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    input  logic             select,
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_toggle
);

    logic sel_q;
    logic sel_d;
    logic sel_toggle_q;
    logic sel_toggle_d;

    // Ternary keeps an unknown select visible as X in simulation; a 0 select takes in1.
    assign out = select ? in2 : in1;

    always_comb begin
        sel_d        = sel_q;
        sel_toggle_d = 1'b0;
        if (reset) begin
            sel_d        = 1'b0;
            sel_toggle_d = 1'b0;
        end else begin
            sel_d        = select;
            sel_toggle_d = (select != sel_q);
        end
    end

    always_ff @(posedge clk) begin
        sel_q        <= sel_d;
        sel_toggle_q <= sel_toggle_d;
    end

    assign sel_toggle = sel_toggle_q;

`ifdef MUX2TO1_OUT_REG_EN
    logic [WIDTH-1:0] out_reg_q;
    logic [WIDTH-1:0] out_reg_d;

    always_comb begin
        out_reg_d = out;
        if (reset) begin
            out_reg_d = RESET_VAL;
        end
    end

    always_ff @(posedge clk) begin
        out_reg_q <= out_reg_d;
    end

    assign out_q = out_reg_q;
`else
    assign out_q = out;
`endif

endmodule

// File: tb/tb_mux2to1.sv
// tb/tb_mux2to1.sv - self-checking bench for mux2to1 with a behavioural reference model
module tb_mux2to1;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0;

    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] out;
    logic         select;
    logic         clk;
    logic         reset;
    logic [W-1:0] out_q;
    logic         sel_toggle;

    int errors;
    int checks;

    // Reference state: select as last captured by a non-reset edge, and the expected registered word.
    logic         prev_sel;
    logic [W-1:0] model_outq;

    mux2to1 #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .in1        (in1),
        .in2        (in2),
        .out        (out),
        .select     (select),
        .clk        (clk),
        .reset      (reset),
        .out_q      (out_q),
        .sel_toggle (sel_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
        logic [W-1:0] pair [2];
        pair[0] = a;
        pair[1] = b;
        return pair[s];
    endfunction

    // Change inputs between edges and check the combinational paths in the same timestep.
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in1    = a;
        in2    = b;
        select = s;
        #1;
        check("out_comb", out, pick(a, b, s));
`ifdef MUX2TO1_OUT_REG_EN
        check("out_q_hold", out_q, model_outq);
`else
        check("out_q_comb", out_q, pick(a, b, s));
`endif
    endtask

    task automatic tick();
        logic         exp_tog;
        logic [W-1:0] exp_reg;
        if (reset) begin
            exp_tog  = 1'b0;
            prev_sel = 1'b0;
            exp_reg  = RV;
        end else begin
            exp_tog  = (select != prev_sel);
            prev_sel = select;
            exp_reg  = pick(in1, in2, select);
        end
        @(posedge clk);
        #1;
        check("sel_toggle", {31'b0, sel_toggle}, {31'b0, exp_tog});
        check("out_edge", out, pick(in1, in2, select));
`ifdef MUX2TO1_OUT_REG_EN
        model_outq = exp_reg;
        check("out_q_reg", out_q, model_outq);
`else
        check("out_q_edge", out_q, pick(in1, in2, select));
`endif
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        prev_sel   = 1'b0;
        model_outq = RV;
        reset      = 1'b1;
        select     = 1'b0;
        in1        = '0;
        in2        = '0;
        tick();
        tick();
        reset = 1'b0;

        // Basic selection, same-timestep output
        drive(32'h0000_0001, 32'h0000_0000, 1'b0);
        check("t1_out", out, 32'h0000_0001);
        drive(32'h0000_0001, 32'h0000_0000, 1'b1);
        check("t2_out", out, 32'h0000_0000);
        tick();

        // Full-width words survive both paths
        drive(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b0);
        check("t3_out0", out, 32'hFFFF_FFFF);
        tick();
        drive(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1);
        check("t3_out1", out, 32'hA5A5_A5A5);
        tick();
        drive(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b0);
        check("t3_out2", out, 32'hFFFF_FFFF);
        tick();

        // Reset coinciding with a select change wins; pulse appears after release
        reset = 1'b1;
        drive(32'hFFFF_FFFF, 32'hA5A5_A5A5, 1'b1);
        check("t4_out_in_reset", out, 32'hA5A5_A5A5);
        tick();
        check("t4_tog_reset1", {31'b0, sel_toggle}, 32'h0);
        tick();
        check("t4_tog_reset2", {31'b0, sel_toggle}, 32'h0);
        reset = 1'b0;
        tick();
        check("t4_tog_release", {31'b0, sel_toggle}, 32'h1);
        tick();
        check("t4_tog_after", {31'b0, sel_toggle}, 32'h0);
        check("t4_out_after", out, 32'hA5A5_A5A5);

        // Data changes without a select change: no pulse
        drive(32'h1111_2222, 32'h3333_4444, 1'b1);
        drive(32'h5555_6666, 32'h7777_8888, 1'b1);
        tick();

        // Registered copy: reset, track, reset mid-stream, resume
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(32'h1234_5678, 32'h0BAD_F00D, 1'b0);
        tick();
`ifdef MUX2TO1_OUT_REG_EN
        check("t5_out_q_track", out_q, 32'h1234_5678);
`else
        check("t6_out_q_track", out_q, 32'h1234_5678);
`endif
        reset = 1'b1;
        drive(32'h8765_4321, 32'h0BAD_F00D, 1'b0);
        tick();
`ifdef MUX2TO1_OUT_REG_EN
        check("t5_out_q_reset", out_q, RV);
`else
        check("t6_out_q_reset", out_q, 32'h8765_4321);
`endif
        reset = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            drive($urandom, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                drive($urandom, $urandom, select);
            end
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
